// File: rtl/branch_unit_if.sv
// Reservation-station, fetch-redirect and link-writeback signals of the branch unit.
// The pred_taken/pred_target pair exists only when BRANCH_PREDICT_EN is defined.
interface branch_unit_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 4,
    parameter int OPW  = 6
);
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] offset_in;
    logic            busy_in;
    logic [OPW-1:0]  op_in;
    logic [TAGW-1:0] tagx_in;
    logic [TAGW-1:0] tagy_in;
    logic [XLEN-1:0] datax_in;
    logic [XLEN-1:0] datay_in;
    logic            done;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            link_valid;
    logic [XLEN-1:0] link_data;
`ifdef BRANCH_PREDICT_EN
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
`endif

    modport master (
        output pc_in, offset_in, busy_in, op_in, tagx_in, tagy_in,
        output datax_in, datay_in, redirect_ready,
`ifdef BRANCH_PREDICT_EN
        output pred_taken, pred_target,
`endif
        input  done, redirect_valid, redirect_pc, link_valid, link_data
    );

    modport slave (
        input  pc_in, offset_in, busy_in, op_in, tagx_in, tagy_in,
        input  datax_in, datay_in, redirect_ready,
`ifdef BRANCH_PREDICT_EN
        input  pred_taken, pred_target,
`endif
        output done, redirect_valid, redirect_pc, link_valid, link_data
    );
endinterface

// File: rtl/branch_unit.sv
// Branch execution unit: captures a ready branch, resolves it, redirects fetch if needed.
// Optional BRANCH_PREDICT_EN: redirect only on mispredict against captured prediction.
module branch_unit #(
    parameter int              XLEN         = 32,
    parameter int              TAGW         = 4,
    parameter logic [TAGW-1:0] TAG_UNLOCKED = '1,
    parameter int              OPW          = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    branch_unit_if.slave  bus
);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(0);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(1);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(2);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(3);
    localparam logic [OPW-1:0] OP_BLTU = OPW'(4);
    localparam logic [OPW-1:0] OP_BGEU = OPW'(5);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6);
    localparam logic [OPW-1:0] OP_JALR = OPW'(7);

    typedef enum logic [1:0] {IDLE, EXEC, REDIR, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] offset_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] datax_q;
    logic [XLEN-1:0] datay_q;
`ifdef BRANCH_PREDICT_EN
    logic            pred_taken_q;
    logic [XLEN-1:0] pred_target_q;
`endif

    logic            operands_ready;
    logic            is_jump;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_val;
    logic            need_redirect;
    logic [XLEN-1:0] redirect_target;

    assign operands_ready = bus.busy_in && (bus.tagx_in == TAG_UNLOCKED)
                                        && (bus.tagy_in == TAG_UNLOCKED);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        taken    = 1'b0;
        is_jump  = 1'b0;
        jalr_sum = datax_q + offset_q;
        link_val = pc_q + XLEN'(4);
        target   = pc_q + offset_q;
        case (op_q)
            OP_BEQ:  taken = (datax_q == datay_q);
            OP_BNE:  taken = (datax_q != datay_q);
            OP_BLT:  taken = ($signed(datax_q) <  $signed(datay_q));
            OP_BGE:  taken = ($signed(datax_q) >= $signed(datay_q));
            OP_BLTU: taken = (datax_q <  datay_q);
            OP_BGEU: taken = (datax_q >= datay_q);
            OP_JAL: begin
                taken   = 1'b1;
                is_jump = 1'b1;
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: taken = 1'b0;
        endcase
`ifdef BRANCH_PREDICT_EN
        need_redirect   = (taken != pred_taken_q) || (taken && (target != pred_target_q));
        redirect_target = taken ? target : link_val;
`else
        need_redirect   = taken;
        redirect_target = target;
`endif
    end

    // Captured operands are reset too, so a reset leaves no stale branch visible anywhere.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            pc_q               <= '0;
            offset_q           <= '0;
            op_q               <= '0;
            datax_q            <= '0;
            datay_q            <= '0;
`ifdef BRANCH_PREDICT_EN
            pred_taken_q       <= 1'b0;
            pred_target_q      <= '0;
`endif
            bus.done           <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.link_valid     <= 1'b0;
            bus.link_data      <= '0;
        end else if (rdy) begin
            bus.done       <= 1'b0;
            bus.link_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (operands_ready) begin
                        pc_q          <= bus.pc_in;
                        offset_q      <= bus.offset_in;
                        op_q          <= bus.op_in;
                        datax_q       <= bus.datax_in;
                        datay_q       <= bus.datay_in;
`ifdef BRANCH_PREDICT_EN
                        pred_taken_q  <= bus.pred_taken;
                        pred_target_q <= bus.pred_target;
`endif
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_jump) begin
                        bus.link_valid <= 1'b1;
                        bus.link_data  <= link_val;
                    end
                    if (need_redirect) begin
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= redirect_target;
                        state              <= REDIR;
                    end else begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                REDIR: begin
                    if (bus.redirect_ready) begin
                        bus.redirect_valid <= 1'b0;
                        bus.done           <= 1'b1;
                        state              <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: table of branch vectors through a scoreboard,
// plus hand sequences for operand wait, redirect stall with rdy=0, and mid-operation reset.
module tb_branch_unit;
    localparam int XLEN = 32;
    localparam int TAGW = 4;
    localparam int OPW  = 6;
    localparam logic [TAGW-1:0] UNL = 4'hF;

    localparam logic [OPW-1:0] OP_BEQ  = 6'd0;
    localparam logic [OPW-1:0] OP_BNE  = 6'd1;
    localparam logic [OPW-1:0] OP_BLT  = 6'd2;
    localparam logic [OPW-1:0] OP_BGE  = 6'd3;
    localparam logic [OPW-1:0] OP_BLTU = 6'd4;
    localparam logic [OPW-1:0] OP_BGEU = 6'd5;
    localparam logic [OPW-1:0] OP_JAL  = 6'd6;
    localparam logic [OPW-1:0] OP_JALR = 6'd7;

    typedef struct {
        logic [OPW-1:0] op;
        logic [31:0]    pc, off, dx, dy;
        bit             redir;
        logic [31:0]    rpc;
        bit             lv;
        logic [31:0]    link;
    } vec_t;

    typedef struct {
        string       name;
        bit          redir;
        logic [31:0] rpc;
        bit          lv;
        logic [31:0] link;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[12];

    branch_unit_if #(.XLEN(XLEN), .TAGW(TAGW), .OPW(OPW)) bus ();

    branch_unit #(.XLEN(XLEN), .TAGW(TAGW), .TAG_UNLOCKED(UNL), .OPW(OPW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rdy  (rdy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        bus.busy_in   = 1'b1;
        bus.tagx_in   = UNL;
        bus.tagy_in   = UNL;
        bus.op_in     = v.op;
        bus.pc_in     = v.pc;
        bus.offset_in = v.off;
        bus.datax_in  = v.dx;
        bus.datay_in  = v.dy;
    endtask

    // Scramble everything after capture; the unit must ignore it.
    task automatic release_inputs();
        bus.busy_in   = 1'b0;
        bus.tagx_in   = 4'h0;
        bus.tagy_in   = 4'h3;
        bus.op_in     = 6'(3'($urandom));
        bus.pc_in     = $urandom;
        bus.offset_in = $urandom;
        bus.datax_in  = $urandom;
        bus.datay_in  = $urandom;
`ifdef BRANCH_PREDICT_EN
        bus.pred_taken  = 1'($urandom);
        bus.pred_target = $urandom;
`endif
    endtask

    task automatic push_exp(input string name, input bit redir, input logic [31:0] rpc,
                            input bit lv, input logic [31:0] link);
        exp_t e;
        e.name  = name;
        e.redir = redir;
        e.rpc   = rpc;
        e.lv    = lv;
        e.link  = link;
        sb.push_back(e);
    endtask

    // Watches one branch from the capture edge to its done pulse, then scores it.
    task automatic observe();
        exp_t        e;
        int          lat;
        bit          saw_r, saw_l, got;
        logic [31:0] rpc, ld;
        lat = 0; saw_r = 1'b0; saw_l = 1'b0; got = 1'b0; rpc = '0; ld = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) release_inputs();
            if (bus.redirect_valid) begin saw_r = 1'b1; rpc = bus.redirect_pc; end
            if (bus.link_valid) begin saw_l = 1'b1; ld = bus.link_data; end
            if (bus.done) begin got = 1'b1; lat = c; end
        end
        if (sb.size() == 0) begin
            check("scoreboard empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, " done seen"}, 32'(got), 32'd1);
            check({e.name, " redirect"}, 32'(saw_r), 32'(e.redir));
            if (e.redir) check({e.name, " redirect_pc"}, rpc, e.rpc);
            check({e.name, " link_valid"}, 32'(saw_l), 32'(e.lv));
            if (e.lv) check({e.name, " link_data"}, ld, e.link);
            check({e.name, " latency"}, 32'(lat), e.redir ? 32'd3 : 32'd2);
        end
        @(posedge clk); #1;
        check("done one cycle", 32'(bus.done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int          ndone;
        bit          seen;
        logic [31:0] any_out;
        vec_t        v;

        tbl[0]  = '{OP_BEQ,  32'h100,      32'h20,       32'd5,        32'd5,        1'b1, 32'h120,  1'b0, 32'h0};
        tbl[1]  = '{OP_BEQ,  32'h100,      32'h20,       32'd5,        32'd6,        1'b0, 32'h0,    1'b0, 32'h0};
        tbl[2]  = '{OP_BNE,  32'h1000,     32'hFFFFFFF0, 32'd5,        32'd6,        1'b1, 32'hFF0,  1'b0, 32'h0};
        tbl[3]  = '{OP_BLT,  32'h40,       32'h8,        32'hFFFFFFFF, 32'd1,        1'b1, 32'h48,   1'b0, 32'h0};
        tbl[4]  = '{OP_BLTU, 32'h40,       32'h8,        32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,    1'b0, 32'h0};
        tbl[5]  = '{OP_BGE,  32'h80,       32'h10,       32'd1,        32'hFFFFFFFF, 1'b1, 32'h90,   1'b0, 32'h0};
        tbl[6]  = '{OP_BGEU, 32'h80,       32'h10,       32'd1,        32'hFFFFFFFF, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[7]  = '{OP_BGE,  32'h0,        32'h4,        32'd7,        32'd7,        1'b1, 32'h4,    1'b0, 32'h0};
        tbl[8]  = '{OP_JAL,  32'hFFFFFFFC, 32'h8,        32'd0,        32'd0,        1'b1, 32'h4,    1'b1, 32'h0};
        tbl[9]  = '{OP_JALR, 32'h200,      32'h0,        32'h1003,     32'd0,        1'b1, 32'h1002, 1'b1, 32'h204};
        tbl[10] = '{OP_JALR, 32'h10,       32'h2,        32'hFFFFFFFF, 32'd0,        1'b1, 32'h0,    1'b1, 32'h14};
        tbl[11] = '{OP_BLTU, 32'h500,      32'h6,        32'd1,        32'd2,        1'b1, 32'h506,  1'b0, 32'h0};

        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.redirect_ready = 1'b1;
        release_inputs();
`ifdef BRANCH_PREDICT_EN
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
`endif
        #12;
        check("reset done", 32'(bus.done), 32'd0);
        check("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("reset link_valid", 32'(bus.link_valid), 32'd0);
        check("reset redirect_pc", bus.redirect_pc, 32'd0);
        check("reset link_data", bus.link_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            drive_vec(tbl[i]);
`ifdef BRANCH_PREDICT_EN
            bus.pred_taken  = 1'b0;
            bus.pred_target = '0;
`endif
            push_exp($sformatf("vec%0d", i), tbl[i].redir, tbl[i].rpc, tbl[i].lv, tbl[i].link);
            observe();
        end

        // Operand X locked for five cycles: nothing may happen until it unlocks.
        v = '{OP_BEQ, 32'h600, 32'h10, 32'd1, 32'd2, 1'b0, 32'h0, 1'b0, 32'h0};
        drive_vec(v);
        bus.tagx_in = 4'h2;
        any_out = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            any_out = any_out | 32'({bus.done, bus.redirect_valid, bus.link_valid});
        end
        check("locked tag no activity", any_out, 32'd0);
        @(negedge clk);
        bus.tagx_in = UNL;
        push_exp("tag unlock", 1'b0, 32'h0, 1'b0, 32'h0);
        observe();

        // Taken BNE stalled on redirect_ready, with rdy low for two of the stall cycles.
        bus.redirect_ready = 1'b0;
        v = '{OP_BNE, 32'h400, 32'h40, 32'd1, 32'd2, 1'b1, 32'h440, 1'b0, 32'h0};
        drive_vec(v);
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1) release_inputs();
            if (bus.redirect_valid) seen = 1'b1;
        end
        check("stall redirect raised", 32'(seen), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            check($sformatf("stall%0d redirect_valid", k), 32'(bus.redirect_valid), 32'd1);
            check($sformatf("stall%0d redirect_pc", k), bus.redirect_pc, 32'h440);
            check($sformatf("stall%0d no done", k), 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rdy = 1'b1;
        bus.redirect_ready = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("stall single done", 32'(ndone), 32'd1);
        @(negedge clk);

        // Reset while a redirect is pending abandons the branch.
        bus.redirect_ready = 1'b0;
        drive_vec(tbl[0]);
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1) release_inputs();
            if (bus.redirect_valid) seen = 1'b1;
        end
        check("abort redirect raised", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("abort redirect_pc", bus.redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.redirect_ready = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.redirect_valid) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        @(negedge clk);
        drive_vec(tbl[9]);
        push_exp("after reset", 1'b1, 32'h1002, 1'b1, 32'h204);
        observe();

`ifdef BRANCH_PREDICT_EN
        drive_vec(tbl[0]);
        bus.pred_taken  = 1'b1;
        bus.pred_target = 32'h120;
        push_exp("pred hit", 1'b0, 32'h0, 1'b0, 32'h0);
        observe();
        v = '{OP_BEQ, 32'h300, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0, 1'b0, 32'h0};
        drive_vec(v);
        bus.pred_taken  = 1'b1;
        bus.pred_target = 32'h340;
        push_exp("pred miss", 1'b1, 32'h304, 1'b0, 32'h0);
        observe();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
